// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry / MRET return sequencer
//
// Purpose: accepts exceptions, interrupts and MRET in IDLE, then steps a short
// fixed sequence that commits the machine trap CSRs and redirects fetch.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   exc_req/code/val    synchronous exception request, cause code, trap value
//   irq_lines[2:0]      pending enabled interrupts: bit0 MSI, bit1 MTI, bit2 MEI
//   mret_req            MRET in execute
//   pc_addr, priv_lvl   faulting PC, current privilege (0=U, 3=M)
//   mstatus_current, mtvec_trap, mepc   current machine CSR values
//   trap_taken/trap_done                commit pulses (entry / return)
//   mepc/mcause/mtval/mstatus_next      values committed on those pulses
//   pc_redirect_valid/pc_redirect       one-cycle fetch redirect
//   priv_next/priv_we                   new privilege and its strobe
//   stall                               high whenever the sequencer is busy
module trap_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exc_req,
    input  logic [3:0]      exc_code,
    input  logic [XLEN-1:0] exc_val,
    input  logic [2:0]      irq_lines,
    input  logic            mret_req,
    input  logic [XLEN-1:0] pc_addr,
    input  logic [1:0]      priv_lvl,
    input  logic [XLEN-1:0] mstatus_current,
    input  logic [XLEN-1:0] mtvec_trap,
    input  logic [XLEN-1:0] mepc,
    output logic            trap_taken,
    output logic            trap_done,
    output logic [XLEN-1:0] mepc_next,
    output logic [XLEN-1:0] mcause_next,
    output logic [XLEN-1:0] mtval_next,
    output logic [XLEN-1:0] mstatus_next,
    output logic            pc_redirect_valid,
    output logic [XLEN-1:0] pc_redirect,
    output logic [1:0]      priv_next,
    output logic            priv_we,
    output logic            stall
);

    typedef enum logic [2:0] {
        IDLE,
        ENTER,
        VECTOR,
        RETURN,
        RET_JUMP
    } state_e;

    state_e          state_q, state_d;
    logic            trap_taken_q, trap_taken_d;
    logic            trap_done_q, trap_done_d;
    logic [XLEN-1:0] mepc_next_q, mepc_next_d;
    logic [XLEN-1:0] mcause_next_q, mcause_next_d;
    logic [XLEN-1:0] mtval_next_q, mtval_next_d;
    logic [XLEN-1:0] mstatus_next_q, mstatus_next_d;
    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_q, redir_d;
    logic [1:0]      priv_next_q, priv_next_d;
    logic            priv_we_q, priv_we_d;
    logic            stall_q, stall_d;
    // Cause and kind of the trap in flight, needed again for vectoring.
    logic [3:0]      cause_q, cause_d;
    logic            is_irq_q, is_irq_d;

    logic            irq_ok;
    logic [3:0]      irq_cause;
    logic            mret_illegal;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] status_enter;
    logic [XLEN-1:0] status_ret;

    assign irq_ok       = (|irq_lines) && (mstatus_current[3] || (priv_lvl != 2'd3));
    assign mret_illegal = mret_req && (priv_lvl != 2'd3);
    assign tvec_base    = {mtvec_trap[XLEN-1:2], 2'b00};

    // MEI > MSI > MTI.
    always_comb begin
        irq_cause = 4'd7;
        if (irq_lines[2]) begin
            irq_cause = 4'd11;
        end else if (irq_lines[0]) begin
            irq_cause = 4'd3;
        end
    end

    always_comb begin
        status_enter        = mstatus_current;
        status_enter[7]     = mstatus_current[3];
        status_enter[3]     = 1'b0;
        status_enter[12:11] = priv_lvl;
        status_ret          = mstatus_current;
        status_ret[3]       = mstatus_current[7];
        status_ret[7]       = 1'b1;
        status_ret[12:11]   = 2'b00;
    end

    always_comb begin
        // Pulses default low; committed values hold until the next sequence.
        state_d        = state_q;
        trap_taken_d   = 1'b0;
        trap_done_d    = 1'b0;
        redir_valid_d  = 1'b0;
        priv_we_d      = 1'b0;
        mepc_next_d    = mepc_next_q;
        mcause_next_d  = mcause_next_q;
        mtval_next_d   = mtval_next_q;
        mstatus_next_d = mstatus_next_q;
        redir_d        = redir_q;
        priv_next_d    = priv_next_q;
        cause_d        = cause_q;
        is_irq_d       = is_irq_q;

        unique case (state_q)
            IDLE: begin
                if (exc_req || irq_ok || mret_illegal) begin
                    state_d        = ENTER;
                    trap_taken_d   = 1'b1;
                    mepc_next_d    = {pc_addr[XLEN-1:2], 2'b00};
                    mstatus_next_d = status_enter;
                    priv_next_d    = 2'd3;
                    priv_we_d      = 1'b1;
                    if (exc_req) begin
                        cause_d       = exc_code;
                        is_irq_d      = 1'b0;
                        mcause_next_d = {{(XLEN-4){1'b0}}, exc_code};
                        mtval_next_d  = exc_val;
                    end else if (irq_ok) begin
                        cause_d       = irq_cause;
                        is_irq_d      = 1'b1;
                        mcause_next_d = {1'b1, {(XLEN-5){1'b0}}, irq_cause};
                        mtval_next_d  = '0;
                    end else begin
                        // MRET below M-mode is an illegal instruction.
                        cause_d       = 4'd2;
                        is_irq_d      = 1'b0;
                        mcause_next_d = {{(XLEN-4){1'b0}}, 4'd2};
                        mtval_next_d  = '0;
                    end
                end else if (mret_req) begin
                    state_d        = RETURN;
                    trap_done_d    = 1'b1;
                    mepc_next_d    = mepc;
                    mstatus_next_d = status_ret;
                    priv_next_d    = mstatus_current[12:11];
                    priv_we_d      = 1'b1;
                end
            end
            ENTER: begin
                state_d       = VECTOR;
                redir_valid_d = 1'b1;
                if (is_irq_q && (mtvec_trap[1:0] == 2'b01)) begin
                    redir_d = tvec_base + {{(XLEN-6){1'b0}}, cause_q, 2'b00};
                end else begin
                    redir_d = tvec_base;
                end
            end
            VECTOR: begin
                state_d = IDLE;
            end
            RETURN: begin
                state_d       = RET_JUMP;
                redir_valid_d = 1'b1;
                redir_d       = {mepc_next_q[XLEN-1:2], 2'b00};
            end
            RET_JUMP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stall_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            trap_taken_q   <= 1'b0;
            trap_done_q    <= 1'b0;
            mepc_next_q    <= '0;
            mcause_next_q  <= '0;
            mtval_next_q   <= '0;
            mstatus_next_q <= '0;
            redir_valid_q  <= 1'b0;
            redir_q        <= '0;
            priv_next_q    <= 2'd0;
            priv_we_q      <= 1'b0;
            stall_q        <= 1'b0;
            cause_q        <= 4'd0;
            is_irq_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            trap_taken_q   <= trap_taken_d;
            trap_done_q    <= trap_done_d;
            mepc_next_q    <= mepc_next_d;
            mcause_next_q  <= mcause_next_d;
            mtval_next_q   <= mtval_next_d;
            mstatus_next_q <= mstatus_next_d;
            redir_valid_q  <= redir_valid_d;
            redir_q        <= redir_d;
            priv_next_q    <= priv_next_d;
            priv_we_q      <= priv_we_d;
            stall_q        <= stall_d;
            cause_q        <= cause_d;
            is_irq_q       <= is_irq_d;
        end
    end

    assign trap_taken        = trap_taken_q;
    assign trap_done         = trap_done_q;
    assign mepc_next         = mepc_next_q;
    assign mcause_next       = mcause_next_q;
    assign mtval_next        = mtval_next_q;
    assign mstatus_next      = mstatus_next_q;
    assign pc_redirect_valid = redir_valid_q;
    assign pc_redirect       = redir_q;
    assign priv_next         = priv_next_q;
    assign priv_we           = priv_we_q;
    assign stall             = stall_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
module tb_trap_ctrl;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            exc_req;
    logic [3:0]      exc_code;
    logic [XLEN-1:0] exc_val;
    logic [2:0]      irq_lines;
    logic            mret_req;
    logic [XLEN-1:0] pc_addr;
    logic [1:0]      priv_lvl;
    logic [XLEN-1:0] mstatus_current;
    logic [XLEN-1:0] mtvec_trap;
    logic [XLEN-1:0] mepc;
    logic            trap_taken;
    logic            trap_done;
    logic [XLEN-1:0] mepc_next;
    logic [XLEN-1:0] mcause_next;
    logic [XLEN-1:0] mtval_next;
    logic [XLEN-1:0] mstatus_next;
    logic            pc_redirect_valid;
    logic [XLEN-1:0] pc_redirect;
    logic [1:0]      priv_next;
    logic            priv_we;
    logic            stall;

    int checks = 0;
    int errors = 0;

    trap_ctrl #(.XLEN(XLEN)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .exc_req           (exc_req),
        .exc_code          (exc_code),
        .exc_val           (exc_val),
        .irq_lines         (irq_lines),
        .mret_req          (mret_req),
        .pc_addr           (pc_addr),
        .priv_lvl          (priv_lvl),
        .mstatus_current   (mstatus_current),
        .mtvec_trap        (mtvec_trap),
        .mepc              (mepc),
        .trap_taken        (trap_taken),
        .trap_done         (trap_done),
        .mepc_next         (mepc_next),
        .mcause_next       (mcause_next),
        .mtval_next        (mtval_next),
        .mstatus_next      (mstatus_next),
        .pc_redirect_valid (pc_redirect_valid),
        .pc_redirect       (pc_redirect),
        .priv_next         (priv_next),
        .priv_we           (priv_we),
        .stall             (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exc_req   = 1'b0;
        irq_lines = 3'b000;
        mret_req  = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        exc_req         = 1'b0;
        exc_code        = 4'd0;
        exc_val         = '0;
        irq_lines       = 3'b000;
        mret_req        = 1'b0;
        pc_addr         = '0;
        priv_lvl        = 2'd0;
        mstatus_current = '0;
        mtvec_trap      = '0;
        mepc            = '0;

        step();
        step();
        check("rst_trap_taken", 64'(trap_taken), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_redir_valid", 64'(pc_redirect_valid), 64'd0);
        check("rst_mepc_next", mepc_next, 64'd0);
        check("rst_priv_we", 64'(priv_we), 64'd0);

        // Exception accepted on the very first edge out of reset.
        rst_n           = 1'b1;
        exc_req         = 1'b1;
        exc_code        = 4'd2;
        exc_val         = 64'h340;
        pc_addr         = 64'h1006;
        priv_lvl        = 2'd0;
        mstatus_current = 64'h8;
        mtvec_trap      = 64'h8000_0000;
        step();
        idle_inputs();
        check("exc_trap_taken", 64'(trap_taken), 64'd1);
        check("exc_mepc", mepc_next, 64'h1004);
        check("exc_mcause", mcause_next, 64'd2);
        check("exc_mtval", mtval_next, 64'h340);
        check("exc_mstatus", mstatus_next, 64'h80);
        check("exc_priv_next", 64'(priv_next), 64'd3);
        check("exc_priv_we", 64'(priv_we), 64'd1);
        check("exc_stall", 64'(stall), 64'd1);
        check("exc_no_redir_yet", 64'(pc_redirect_valid), 64'd0);
        step();
        check("exc_redir_valid", 64'(pc_redirect_valid), 64'd1);
        check("exc_redir", pc_redirect, 64'h8000_0000);
        check("exc_taken_cleared", 64'(trap_taken), 64'd0);
        check("exc_priv_we_cleared", 64'(priv_we), 64'd0);
        check("exc_priv_hold", 64'(priv_next), 64'd3);
        step();
        check("exc_back_idle_stall", 64'(stall), 64'd0);
        check("exc_redir_cleared", 64'(pc_redirect_valid), 64'd0);

        // All three interrupts, vectored mode: MEI wins, base + 44.
        irq_lines       = 3'b111;
        mstatus_current = 64'h8;
        priv_lvl        = 2'd3;
        pc_addr         = 64'h2222;
        mtvec_trap      = 64'h8000_0001;
        step();
        idle_inputs();
        check("mei_taken", 64'(trap_taken), 64'd1);
        check("mei_mcause", mcause_next, 64'h8000_0000_0000_000B);
        check("mei_mtval", mtval_next, 64'd0);
        check("mei_mepc", mepc_next, 64'h2220);
        check("mei_mstatus", mstatus_next, 64'h1880);
        step();
        check("mei_redir", pc_redirect, 64'h8000_002C);
        step();

        // MSI beats MTI.
        irq_lines = 3'b011;
        step();
        idle_inputs();
        check("msi_mcause", mcause_next, 64'h8000_0000_0000_0003);
        step();
        check("msi_redir", pc_redirect, 64'h8000_000C);
        step();

        // MTI masked in M-mode with MIE=0.
        irq_lines       = 3'b010;
        mstatus_current = 64'h0;
        priv_lvl        = 2'd3;
        step();
        check("mti_masked_taken", 64'(trap_taken), 64'd0);
        check("mti_masked_stall", 64'(stall), 64'd0);
        // Same interrupt from U-mode is always eligible.
        priv_lvl = 2'd0;
        step();
        idle_inputs();
        check("mti_u_taken", 64'(trap_taken), 64'd1);
        check("mti_u_mcause", mcause_next, 64'h8000_0000_0000_0007);
        check("mti_u_mstatus", mstatus_next, 64'h0);
        step();
        check("mti_u_redir", pc_redirect, 64'h8000_001C);
        step();

        // MRET from M-mode, MPP=M.
        mret_req        = 1'b1;
        priv_lvl        = 2'd3;
        mstatus_current = 64'h1880;
        mepc            = 64'h2000;
        step();
        idle_inputs();
        check("mret_done", 64'(trap_done), 64'd1);
        check("mret_not_taken", 64'(trap_taken), 64'd0);
        check("mret_mstatus", mstatus_next, 64'h0088);
        check("mret_priv_next", 64'(priv_next), 64'd3);
        check("mret_priv_we", 64'(priv_we), 64'd1);
        check("mret_mepc_echo", mepc_next, 64'h2000);
        check("mret_mcause_echo", mcause_next, 64'h8000_0000_0000_0007);
        step();
        check("mret_redir_valid", 64'(pc_redirect_valid), 64'd1);
        check("mret_redir", pc_redirect, 64'h2000);
        check("mret_done_cleared", 64'(trap_done), 64'd0);
        step();

        // MRET with MPP=U, misaligned mepc.
        mret_req        = 1'b1;
        mstatus_current = 64'h0080;
        mepc            = 64'h2003;
        step();
        idle_inputs();
        check("mret_u_priv_next", 64'(priv_next), 64'd0);
        check("mret_u_mstatus", mstatus_next, 64'h0088);
        step();
        check("mret_u_redir", pc_redirect, 64'h2000);
        step();

        // MRET from U-mode is an illegal instruction.
        mret_req        = 1'b1;
        priv_lvl        = 2'd0;
        mstatus_current = 64'h0;
        pc_addr         = 64'h3000;
        mtvec_trap      = 64'h4000_0000;
        step();
        idle_inputs();
        check("ill_mret_taken", 64'(trap_taken), 64'd1);
        check("ill_mret_done", 64'(trap_done), 64'd0);
        check("ill_mret_mcause", mcause_next, 64'd2);
        check("ill_mret_mtval", mtval_next, 64'd0);
        check("ill_mret_mepc", mepc_next, 64'h3000);
        step();
        check("ill_mret_redir", pc_redirect, 64'h4000_0000);
        step();

        // Exception and MRET together; second exception during ENTER dropped.
        exc_req  = 1'b1;
        exc_code = 4'd5;
        exc_val  = 64'h77;
        mret_req = 1'b1;
        priv_lvl = 2'd3;
        pc_addr  = 64'h100;
        step();
        mret_req = 1'b0;
        exc_code = 4'd7;
        check("both_taken", 64'(trap_taken), 64'd1);
        check("both_not_done", 64'(trap_done), 64'd0);
        check("both_mcause", mcause_next, 64'd5);
        step();
        idle_inputs();
        check("busy_ignore_mcause", mcause_next, 64'd5);
        check("busy_ignore_taken", 64'(trap_taken), 64'd0);
        step();
        check("busy_ignore_idle", 64'(stall), 64'd0);
        check("busy_ignore_no_taken", 64'(trap_taken), 64'd0);

        // Reset in ENTER abandons the trap.
        exc_req  = 1'b1;
        exc_code = 4'd4;
        step();
        idle_inputs();
        check("rst_mid_taken_before", 64'(trap_taken), 64'd1);
        rst_n = 1'b0;
        step();
        check("rst_mid_taken", 64'(trap_taken), 64'd0);
        check("rst_mid_redir", 64'(pc_redirect_valid), 64'd0);
        check("rst_mid_stall", 64'(stall), 64'd0);
        check("rst_mid_mcause", mcause_next, 64'd0);
        check("rst_mid_priv_we", 64'(priv_we), 64'd0);
        rst_n = 1'b1;
        step();
        check("rst_mid_after_redir", 64'(pc_redirect_valid), 64'd0);
        check("rst_mid_after_stall", 64'(stall), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter: XLEN, 64, data/address width of all CSR-valued ports.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 exc_req, exc_code, exc_val  input  1/4/XLEN  synchronous exception request, its cause code and trap value.
REQ-005 irq_lines  input  3  pending machine interrupts (mip&mie): bit0 MSI, bit1 MTI, bit2 MEI.
REQ-006 mret_req  input  1  MRET instruction in execute.
REQ-007 pc_addr, priv_lvl  input  XLEN/2  PC of the faulting instruction; current privilege (0=U, 3=M).
REQ-008 mstatus_current, mtvec_trap, mepc  input  XLEN each  CSR values from the machine CSR file.
REQ-009 trap_taken, trap_done  output  1 each  one-cycle pulses that commit mepc/mcause/mtval/mstatus_next into the CSR file.
REQ-010 mepc_next, mcause_next, mtval_next, mstatus_next  output  XLEN each  values committed on trap_taken/trap_done.
REQ-011 pc_redirect_valid, pc_redirect  output  1/XLEN  one-cycle fetch redirect and its target.
REQ-012 priv_next, priv_we  output  2/1  new privilege and its write strobe.
REQ-013 stall  output  1  freezes pipeline while the FSM is not IDLE.

Function
REQ-014 FSM states: IDLE, ENTER, VECTOR, RETURN, RET_JUMP; all outputs registered.
REQ-015 In IDLE, priority: exc_req > interrupt > mret_req; lower-priority requests in the same cycle are dropped.
REQ-016 Interrupt eligible only when mstatus_current[3] (MIE)=1 or priv_lvl<3; selection among eligible lines: MEI(cause 11) > MSI(3) > MTI(7).
REQ-017 IDLE->ENTER on accepted exception/interrupt; ENTER->VECTOR; VECTOR->IDLE; IDLE->RETURN on mret_req; RETURN->RET_JUMP; RET_JUMP->IDLE.
REQ-018 ENTER: trap_taken=1 for exactly one cycle; mepc_next=pc_addr with bits [1:0] cleared, sampled at acceptance.
REQ-019 ENTER: mcause_next={60'b0,exc_code} for exceptions; {1'b1, 59'b0, irq cause[3:0]} for interrupts.
REQ-020 ENTER: mtval_next=exc_val for exceptions, 0 for interrupts.
REQ-021 ENTER: mstatus_next = mstatus_current with MPIE(bit7)<=MIE(bit3), MIE<=0, MPP(12:11)<=priv_lvl; other bits unchanged; priv_next=3, priv_we=1.
REQ-022 VECTOR: pc_redirect_valid=1; base={mtvec_trap[XLEN-1:2],2'b00}; target=base+4*cause for interrupts when mtvec_trap[1:0]=1, else base (modes 2/3 treated as direct); arithmetic modulo 2^XLEN.
REQ-023 RETURN: trap_done=1 for one cycle; mstatus_next: MIE<=MPIE, MPIE<=1, MPP<=0; mepc_next/mcause_next/mtval_next echo current values unchanged; priv_next=old MPP, priv_we=1.
REQ-024 RET_JUMP: pc_redirect_valid=1, pc_redirect=mepc with bits [1:0] cleared.
REQ-025 mret_req with priv_lvl<3 is treated as exception cause 2, mtval_next=0 (not as a return).
REQ-026 stall=1 in every non-IDLE state; all requests arriving outside IDLE are ignored.
REQ-027 Latency: accepted request in cycle N -> commit pulse N+1 -> redirect N+2 -> IDLE and new acceptance possible N+3.
REQ-028 Pulse outputs (trap_taken, trap_done, pc_redirect_valid, priv_we) are 0 in every state not listed above.

Reset
REQ-029 rst_n=0 at a clock edge: state=IDLE, all outputs 0, including mid-sequence; a pending trap is abandoned without commit pulses.
REQ-030 First acceptance possible on the first edge with rst_n=1.

Verification
REQ-031 exc_req=1, code 2, exc_val=0x340, pc=0x1006, priv=0, mstatus=0x8, mtvec=0x8000_0000 -> N+1 trap_taken, mepc_next=0x1004, mcause_next=2, mtval_next=0x340, mstatus_next=0x80; N+2 redirect to 0x8000_0000, priv_next=3.
REQ-032 irq_lines=3'b111, MIE=1, mtvec=0x8000_0001 -> mcause_next=0x8000_0000_0000_000B, mtval_next=0; redirect 0x8000_002C.
REQ-033 irq_lines=3'b010, MIE=0, priv=3 -> no trap_taken, stall stays 0; same with priv=0 -> cause 0x8000_0000_0000_0007 taken.
REQ-034 mret_req, priv=3, mstatus=0x1880, mepc=0x2000 -> trap_done, mstatus_next=0x0088, priv_next=3; next cycle redirect 0x2000; with mstatus=0x0080 -> priv_next=0.
REQ-035 exc_req and mret_req together -> exception path only; new exc_req during ENTER ignored.
REQ-036 rst_n=0 asserted in ENTER -> next cycle all outputs 0, state IDLE, no pc_redirect_valid pulse.
